// File: rtl/scan_chain_loader_if.sv
// rtl/scan_chain_loader_if.sv - configuration word valid/ready handshake between host and scan loader
interface scan_chain_loader_if #(
  parameter int WORD_W = 16
);
  logic              cfg_valid;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_ready;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/scan_chain_loader.sv
// rtl/scan_chain_loader.sv - serialises configuration words LSB-first onto a scan chain
// Optional readback of the old chain contents: define SCAN_READBACK_EN.
module scan_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  scan_chain_loader_if.slave  cfg,
  output logic                scan_se,
  output logic                scan_si,
  input  logic                scan_so,
  output logic                busy,
  output logic                done,
  output logic                rb_valid,
  output logic [WORD_W-1:0]   rb_data
);

  localparam int TCW = $clog2(CHAIN_LEN + 1);
  localparam int WCW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic [TCW-1:0]    total_cnt_q, total_cnt_d;
  logic [TCW-1:0]    remaining;
  logic              cfg_ready_q, cfg_ready_d;
  logic              scan_se_q, scan_se_d;
  logic              scan_si_q, scan_si_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;

  // Word is taken only while sitting in WAIT_WORD with ready already asserted.
  assign accept = (state_q == S_WAIT_WORD) && cfg.cfg_valid && cfg_ready_q;

  // Next-state, shift register and counters; outputs are decoded from the next state so they are registered.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    word_cnt_d  = word_cnt_q;
    total_cnt_d = total_cnt_q;
    remaining   = TCW'(CHAIN_LEN) - total_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WAIT_WORD;
          total_cnt_d = '0;
        end
      end
      S_WAIT_WORD: begin
        if (accept) begin
          sreg_d     = cfg.cfg_data;
          // The final word may be clipped so no bit beyond the chain is ever shifted.
          word_cnt_d = (32'(remaining) >= WORD_W) ? WCW'(WORD_W) : WCW'(remaining);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sreg_d      = sreg_q >> 1;
        word_cnt_d  = word_cnt_q - 1'b1;
        total_cnt_d = total_cnt_q + 1'b1;
        if (word_cnt_q == WCW'(1)) begin
          state_d = (total_cnt_q + 1'b1 == TCW'(CHAIN_LEN)) ? S_DONE : S_WAIT_WORD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cfg_ready_d = (state_d == S_WAIT_WORD);
    scan_se_d   = (state_d == S_SHIFT);
    scan_si_d   = scan_se_d & sreg_d[0];
    busy_d      = (state_d == S_WAIT_WORD) || (state_d == S_SHIFT);
    done_d      = (state_d == S_DONE);
  end

  // State and registered outputs; reset drops scan enable immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      word_cnt_q  <= '0;
      total_cnt_q <= '0;
      cfg_ready_q <= 1'b0;
      scan_se_q   <= 1'b0;
      scan_si_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      word_cnt_q  <= word_cnt_d;
      total_cnt_q <= total_cnt_d;
      cfg_ready_q <= cfg_ready_d;
      scan_se_q   <= scan_se_d;
      scan_si_q   <= scan_si_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign scan_se       = scan_se_q;
  assign scan_si       = scan_si_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef SCAN_READBACK_EN
  logic [WORD_W-1:0] rb_acc_q, rb_acc_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic [WCW-1:0]    rb_idx_q, rb_idx_d;
  logic              rb_valid_q, rb_valid_d;

  // Collect the bits leaving the chain tail, i-th bit of the word into position i.
  always_comb begin
    rb_acc_d   = rb_acc_q;
    rb_data_d  = rb_data_q;
    rb_idx_d   = rb_idx_q;
    rb_valid_d = 1'b0;
    if (accept) begin
      rb_acc_d = '0;
      rb_idx_d = '0;
    end else if (state_q == S_SHIFT) begin
      rb_acc_d = rb_acc_q | (WORD_W'(scan_so) << rb_idx_q);
      rb_idx_d = rb_idx_q + 1'b1;
      if (word_cnt_q == WCW'(1)) begin
        rb_data_d  = rb_acc_d;
        rb_valid_d = 1'b1;
      end
    end
  end

  // Readback registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_acc_q   <= '0;
      rb_data_q  <= '0;
      rb_idx_q   <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_acc_q   <= rb_acc_d;
      rb_data_q  <= rb_data_d;
      rb_idx_q   <= rb_idx_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_data_q;
`else
  logic unused_scan_so;
  assign unused_scan_so = scan_so;
  assign rb_valid       = 1'b0;
  assign rb_data        = '0;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// tb/tb_scan_chain_loader.sv - table-driven bench for scan_chain_loader with behavioural scan chains
module tb_scan_chain_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        se_a, si_a, so_a, busy_a, done_a, rbv_a;
  logic        se_b, si_b, so_b, busy_b, done_b, rbv_b;
  logic [15:0] rbd_a;
  logic [7:0]  rbd_b;
  logic [63:0] qa;
  logic [19:0] qb;
  logic        preload_a = 1'b0;
  logic [63:0] preload_val = '0;
  logic [15:0] rb_q[$];
  int          checks = 0;
  int          errors = 0;

  scan_chain_loader_if #(.WORD_W(16)) if_a ();
  scan_chain_loader_if #(.WORD_W(8))  if_b ();

  scan_chain_loader #(.CHAIN_LEN(64), .WORD_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cfg(if_a.slave),
    .scan_se(se_a), .scan_si(si_a), .scan_so(so_a), .busy(busy_a),
    .done(done_a), .rb_valid(rbv_a), .rb_data(rbd_a)
  );

  scan_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cfg(if_b.slave),
    .scan_se(se_b), .scan_si(si_b), .scan_so(so_b), .busy(busy_b),
    .done(done_b), .rb_valid(rbv_b), .rb_data(rbd_b)
  );

  always #5 clk = ~clk;

  // Chain models: head at the top bit, tail q[0] drives scan_so.
  always @(posedge clk) begin
    if (preload_a) qa <= preload_val;
    else if (se_a) qa <= {si_a, qa[63:1]};
  end
  always @(posedge clk) if (se_b) qb <= {si_b, qb[19:1]};
  assign so_a = qa[0];
  assign so_b = qb[0];

  always @(negedge clk) if (rbv_a) rb_q.push_back(rbd_a);

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic              sel;
    logic [3:0][15:0]  w;
    int                nw;
    int                stall_word;
    int                stall_len;
    logic              poke;
    logic [63:0]       exp_q;
    int                exp_done;
    int                exp_se;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic st, input logic vld, input logic [15:0] d);
    if (sel) begin
      start_b = st; if_b.cfg_valid = vld; if_b.cfg_data = d[7:0];
    end else begin
      start_a = st; if_a.cfg_valid = vld; if_a.cfg_data = d;
    end
  endtask

  task automatic run_load(input vec_t v, input string nm);
    int k, done_cyc, se_cnt, busy_cnt, stall_rem, extra;
    logic st, vld, hs, rdy, se, bsy, dn;
    logic [15:0] dat;
    logic [63:0] snap, q;
    k = 0; done_cyc = 0; se_cnt = 0; busy_cnt = 0; stall_rem = v.stall_len;
    hs = 1'b0; snap = '0;
    @(negedge clk);
    st = 1'b1; vld = 1'b1; dat = v.w[0];
    drive(v.sel, st, vld, dat);
    @(posedge clk);
    for (int c = 1; c <= 400 && done_cyc == 0; c++) begin
      @(negedge clk);
      st = 1'b0;
      if (hs) begin
        k++;
        dat = v.w[(k < 4) ? k : 3];
      end
      rdy = v.sel ? if_b.cfg_ready : if_a.cfg_ready;
      se  = v.sel ? se_b : se_a;
      bsy = v.sel ? busy_b : busy_a;
      dn  = v.sel ? done_b : done_a;
      q   = v.sel ? {44'd0, qb} : qa;
      if (se) se_cnt++;
      if (bsy) busy_cnt++;
      if (dn) done_cyc = c;
      if (v.poke && ((se && se_cnt == 3) || dn)) st = 1'b1;
      if (k >= v.nw) begin
        vld = 1'b0;
      end else if (rdy && k == v.stall_word && stall_rem > 0) begin
        if (stall_rem == v.stall_len) snap = q;
        else check({nm, "_stall_q"}, q, snap);
        check({nm, "_stall_se"}, 64'(se), 64'd0);
        stall_rem--;
        vld = 1'b0;
      end else begin
        vld = 1'b1;
      end
      hs = rdy & vld;
      drive(v.sel, st, vld, dat);
    end
    @(negedge clk);
    drive(v.sel, 1'b0, 1'b0, dat);
    q = v.sel ? {44'd0, qb} : qa;
    check({nm, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
    check({nm, "_se_cycles"}, 64'(se_cnt), 64'(v.exp_se));
    check({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(v.exp_done - 1));
    check({nm, "_chain_q"}, q, v.exp_q);
    if (v.poke) begin
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if ((v.sel ? (busy_b | done_b) : (busy_a | done_a))) extra++;
      end
      check({nm, "_no_second_load"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    int cnt;
    vec_t rbv;
    logic [15:0] exp_rb[4];

    tbl[0] = '{sel: 1'b0, w: {16'hFFFF, 16'h0F0F, 16'hABCD, 16'h1234}, nw: 4,
               stall_word: -1, stall_len: 0, poke: 1'b0,
               exp_q: 64'hFFFF0F0FABCD1234, exp_done: 69, exp_se: 64};
    tbl[1] = '{sel: 1'b0, w: {16'hFFFF, 16'h0F0F, 16'hABCD, 16'h1234}, nw: 4,
               stall_word: 2, stall_len: 5, poke: 1'b0,
               exp_q: 64'hFFFF0F0FABCD1234, exp_done: 74, exp_se: 64};
    tbl[2] = '{sel: 1'b0, w: {16'h5555, 16'hFFFF, 16'h0000, 16'h8001}, nw: 4,
               stall_word: -1, stall_len: 0, poke: 1'b1,
               exp_q: 64'h5555FFFF00008001, exp_done: 69, exp_se: 64};
    tbl[3] = '{sel: 1'b1, w: {16'h0000, 16'h00FF, 16'h003C, 16'h00A5}, nw: 3,
               stall_word: -1, stall_len: 0, poke: 1'b0,
               exp_q: 64'h00000000000F3CA5, exp_done: 24, exp_se: 20};
    tbl[4] = '{sel: 1'b1, w: {16'h0000, 16'h0001, 16'h00FF, 16'h0000}, nw: 3,
               stall_word: 1, stall_len: 3, poke: 1'b0,
               exp_q: 64'h000000000001FF00, exp_done: 27, exp_se: 20};

    if_a.cfg_valid = 1'b0; if_a.cfg_data = '0;
    if_b.cfg_valid = 1'b0; if_b.cfg_data = '0;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst_a_ready", 64'(if_a.cfg_ready), 64'd0);
    check("rst_a_se", 64'(se_a), 64'd0);
    check("rst_a_si", 64'(si_a), 64'd0);
    check("rst_a_busy", 64'(busy_a), 64'd0);
    check("rst_a_done", 64'(done_a), 64'd0);
    check("rst_a_rb", {47'd0, rbv_a, rbd_a}, 64'd0);
    check("rst_b_outs", {52'd0, if_b.cfg_ready, se_b, si_b, busy_b, done_b, rbv_b, rbd_b}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_a_busy", 64'(busy_a), 64'd0);

    // Reset in the middle of shifting word 0.
    start_a = 1'b1; if_a.cfg_valid = 1'b1; if_a.cfg_data = 16'h1234;
    @(negedge clk);
    start_a = 1'b0;
    check("midrst_wait_ready", 64'(if_a.cfg_ready), 64'd1);
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 10; i++) begin
      @(negedge clk);
      if (se_a) cnt++;
    end
    check("midrst_shifts", 64'(cnt), 64'd10);
    #2 reset = 1'b1;
    #1;
    check("midrst_se", 64'(se_a), 64'd0);
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_ready", 64'(if_a.cfg_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    if_a.cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_idle_busy", 64'(busy_a), 64'd0);

    for (int i = 0; i < 5; i++) begin
      run_load(tbl[i], $sformatf("vec%0d", i));
    end

`ifdef SCAN_READBACK_EN
    rb_q.delete();
    @(negedge clk);
    preload_val = 64'hDEADBEEFCAFEF00D;
    preload_a = 1'b1;
    @(negedge clk);
    preload_a = 1'b0;
    check("rb_preload", qa, 64'hDEADBEEFCAFEF00D);
    rbv = '{sel: 1'b0, w: '0, nw: 4, stall_word: -1, stall_len: 0, poke: 1'b0,
            exp_q: 64'd0, exp_done: 69, exp_se: 64};
    run_load(rbv, "rb_load");
    exp_rb = '{16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD};
    check("rb_count", 64'(rb_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < rb_q.size(); i++) begin
      check($sformatf("rb_word%0d", i), 64'(rb_q[i]), 64'(exp_rb[i]));
    end
`else
    check("rb_none_seen", 64'(rb_q.size()), 64'd0);
    check("rb_data_zero", 64'(rbd_a), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
